// File: rtl/adder.sv
// adder: WIDTH-bit up-counter with synchronous clear and increment.
// Wraps modulo 2^WIDTH, or holds at all-ones when SATURATE is set.
module adder #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             at_max;
    logic             hold_max;

    assign at_max   = &cnt_q;
    assign hold_max = SATURATE && at_max;
    assign cnt_inc  = cnt_q + WIDTH'(1);

    // Ternaries let an X on clr or inc propagate instead of
    // silently falling into an else branch.
    always_comb begin
        cnt_d = cnt_q;
        cnt_d = clr ? '0
              : inc ? (hold_max ? cnt_q : cnt_inc)
              : cnt_q;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: tb/tb_adder.sv
// tb_adder: table-driven vectors plus a per-edge scoreboard over a
// wrapping, a saturating and a 1-bit counter sharing one stimulus.
module tb_adder;

    logic       aclk;
    logic       arstn;
    logic       clr;
    logic       inc;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [0:0] out2;

    int checks;
    int errors;

    logic [7:0] m0;
    logic [7:0] m1;
    logic [0:0] m2;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [0:0] q2[$];
    bit         wrap_seen;

    typedef struct {
        string      name;
        logic       c;
        logic       i;
        int         reps;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vecs[9];

    adder #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .aclk(aclk), .arstn(arstn), .clr(clr), .inc(inc), .out(out0)
    );

    adder #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
        .aclk(aclk), .arstn(arstn), .clr(clr), .inc(inc), .out(out1)
    );

    adder #(1) u_w1 (
        .aclk(aclk), .arstn(arstn), .clr(clr), .inc(inc), .out(out2)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #100us;
        $display("FAIL watchdog: time limit expired");
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic i);
        logic [7:0] p0;
        @(negedge aclk);
        clr = c;
        inc = i;
        p0  = out0;
        m0  = c ? 8'd0 : i ? m0 + 8'd1 : m0;
        m1  = c ? 8'd0 : i ? ((m1 == 8'd255) ? m1 : m1 + 8'd1) : m1;
        m2  = c ? 1'b0 : i ? ~m2 : m2;
        q0.push_back(m0);
        q1.push_back(m1);
        q2.push_back(m2);
        @(posedge aclk);
        #1;
        if (p0 == 8'd255 && out0 == 8'd0) wrap_seen = 1'b1;
        check("sb_wrap", out0, q0.pop_front());
        check("sb_sat", out1, q1.pop_front());
        check("sb_w1", {7'd0, out2}, {7'd0, q2.pop_front()});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        wrap_seen = 1'b0;
        m0 = '0;
        m1 = '0;
        m2 = '0;

        vecs[0] = '{"inc_once",   1'b0, 1'b1,   1, 8'd1,  8'd1};
        vecs[1] = '{"hold_one",   1'b0, 1'b0,   3, 8'd1,  8'd1};
        vecs[2] = '{"clear",      1'b1, 1'b0,   1, 8'd0,  8'd0};
        vecs[3] = '{"inc_300",    1'b0, 1'b1, 300, 8'd44, 8'd255};
        vecs[4] = '{"hold_300",   1'b0, 1'b0,   2, 8'd44, 8'd255};
        vecs[5] = '{"clr_sat",    1'b1, 1'b0,   1, 8'd0,  8'd0};
        vecs[6] = '{"inc_5",      1'b0, 1'b1,   5, 8'd5,  8'd5};
        vecs[7] = '{"clr_inc",    1'b1, 1'b1,   1, 8'd0,  8'd0};
        vecs[8] = '{"inc_256",    1'b0, 1'b1, 256, 8'd0,  8'd255};

        // Reset held 100 ns with idle inputs, stray edges ignored.
        arstn = 1'b0;
        clr   = 1'b0;
        inc   = 1'b0;
        #100;
        check("rst_wrap", out0, 8'd0);
        check("rst_sat", out1, 8'd0);
        check("rst_x", {7'd0, $isunknown(out0)}, 8'd0);
        @(negedge aclk);
        arstn = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        check("idle_zero", out0, 8'd0);

        for (int v = 0; v < 9; v++) begin
            for (int r = 0; r < vecs[v].reps; r++)
                step(vecs[v].c, vecs[v].i);
            check({vecs[v].name, "_wrap"}, out0, vecs[v].e0);
            check({vecs[v].name, "_sat"}, out1, vecs[v].e1);
            if (v == 0) check("inc_once_nz", {7'd0, out0 != 8'd0}, 8'd1);
            if (v == 3) check("wrap_seen", {7'd0, wrap_seen}, 8'd1);
        end

        // Bring both counters to 7, then reset between edges.
        step(1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1);
        check("pre_rst", out0, 8'd7);
        @(posedge aclk);
        #2;
        arstn = 1'b0;
        m0 = '0;
        m1 = '0;
        m2 = '0;
        #1;
        check("async_wrap", out0, 8'd0);
        check("async_sat", out1, 8'd0);
        inc = 1'b1;
        clr = 1'b0;
        @(posedge aclk);
        #1;
        check("rst_ignores_inc", out0, 8'd0);
        @(negedge aclk);
        inc   = 1'b0;
        arstn = 1'b1;
        step(1'b0, 1'b1);
        check("restart_wrap", out0, 8'd1);
        check("restart_sat", out1, 8'd1);
        step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
